// File: rtl/async_fifo_pkg.sv
// Shared defaults and pointer-encoding helper for the Gray-pointer FIFO.
package async_fifo_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_DEPTH       = 8;
    localparam int DEF_SYNC_STAGES = 2;

    // Widest pointer the helper handles; callers zero-extend in and cast the result back down.
    localparam int GRAY_MAX_W = 32;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Multi-flop synchroniser chain for a Gray-coded pointer; clears to zero on reset.
module fifo_ptr_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk_sys,
    input  logic             rst_b,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain_q [STAGES];
    logic [WIDTH-1:0] chain_d [STAGES];

    always_comb begin
        chain_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            chain_d[i] = chain_q[i-1];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_b) begin
            chain_q <= '{default: '0};
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/async_fifo.sv
// Circular-buffer FIFO with Gray pointers crossing through synchronisers; flags are conservative.
module async_fifo
    import async_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int ADDR_WIDTH  = $clog2(DEPTH),
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  W_INC,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    output logic                  FULL,
    input  logic                  R_INC,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  EMPTY
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] wbin_q, wbin_d, wgray_q, wgray_d;
    logic [PW-1:0] rbin_q, rbin_d, rgray_q, rgray_d;
    logic [PW-1:0] wq_rgray, rq_wgray, full_cmp;
    logic          full_q, full_d, empty_q, empty_d;
    logic          push, pop;

    // Write side: pointer advance and FULL against the synchronised read pointer.
    always_comb begin
        push     = W_INC & ~full_q;
        wbin_d   = wbin_q + PW'(push);
        wgray_d  = PW'(bin2gray(GRAY_MAX_W'(wbin_d)));
        full_cmp = {~rq_wgray[PW-1:PW-2], rq_wgray[PW-3:0]};
        full_d   = (wgray_d == full_cmp);
    end

    always_comb begin
        pop     = R_INC & ~empty_q;
        rbin_d  = rbin_q + PW'(pop);
        rgray_d = PW'(bin2gray(GRAY_MAX_W'(rbin_d)));
        empty_d = (rgray_d == wq_rgray);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            full_q  <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            full_q  <= full_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            rbin_q  <= '0;
            rgray_q <= '0;
            empty_q <= 1'b1;
        end else begin
            rbin_q  <= rbin_d;
            rgray_q <= rgray_d;
            empty_q <= empty_d;
        end
    end

    // Storage is deliberately not reset; a push during reset is dropped.
    always_ff @(posedge CLK) begin
        if (push && RST) begin
            mem_q[wbin_q[ADDR_WIDTH-1:0]] <= WR_DATA;
        end
    end

    fifo_ptr_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_sync_w2r (
        .clk_sys (CLK),
        .rst_b   (RST),
        .d       (wgray_q),
        .q       (wq_rgray)
    );

    fifo_ptr_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_sync_r2w (
        .clk_sys (CLK),
        .rst_b   (RST),
        .d       (rgray_q),
        .q       (rq_wgray)
    );

    assign RD_DATA = mem_q[rbin_q[ADDR_WIDTH-1:0]];
    assign FULL    = full_q;
    assign EMPTY   = empty_q;

endmodule

// File: tb/tb_async_fifo.sv
// Directed plus random bench for async_fifo, checked against a count/queue reference model.
module tb_async_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int S     = 2;
    localparam int LAG   = S + 1;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          W_INC = 1'b0;
    logic          R_INC = 1'b0;
    logic [DW-1:0] WR_DATA = '0;
    logic          FULL, EMPTY;
    logic [DW-1:0] RD_DATA;

    int errors = 0;
    int checks = 0;

    // Reference: data queue plus push/pop totals; each flag sees the other side's total LAG edges late.
    logic [DW-1:0] mq[$];
    int            wh[LAG+1];
    int            rh[LAG+1];
    bit            m_full, m_empty;
    string         phase;

    async_fifo #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .ADDR_WIDTH  (3),
        .SYNC_STAGES (S)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .W_INC   (W_INC),
        .WR_DATA (WR_DATA),
        .FULL    (FULL),
        .R_INC   (R_INC),
        .RD_DATA (RD_DATA),
        .EMPTY   (EMPTY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d checks=%0d)", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s: observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i <= LAG; i++) begin
            wh[i] = 0;
            rh[i] = 0;
        end
        m_full  = 1'b0;
        m_empty = 1'b1;
    endtask

    task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r);
        bit do_push, do_pop;
        W_INC   = w;
        WR_DATA = d;
        R_INC   = r;
        @(posedge CLK);
        do_push = w && !m_full;
        do_pop  = r && !m_empty;
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(d);
        for (int i = LAG; i > 0; i--) begin
            wh[i] = wh[i-1];
            rh[i] = rh[i-1];
        end
        wh[0] = wh[0] + int'(do_push);
        rh[0] = rh[0] + int'(do_pop);
        m_empty = (rh[0] == wh[LAG]);
        m_full  = ((wh[0] - rh[LAG]) == DEPTH);
        #1;
        W_INC = 1'b0;
        R_INC = 1'b0;
        chk("empty", {7'b0, EMPTY}, {7'b0, m_empty});
        chk("full", {7'b0, FULL}, {7'b0, m_full});
        if (!m_empty) chk("rd_data", RD_DATA, mq[0]);
    endtask

    task automatic do_reset(input int n);
        W_INC = 1'b0;
        R_INC = 1'b0;
        RST   = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
        RST = 1'b1;
        model_reset();
        chk("rst_empty", {7'b0, EMPTY}, 8'h01);
        chk("rst_full", {7'b0, FULL}, 8'h00);
    endtask

    task automatic wait_data(input int budget);
        int n = 0;
        while (EMPTY !== 1'b0 && n < budget) begin
            cycle(1'b0, '0, 1'b0);
            n++;
        end
        checks++;
        assert (EMPTY === 1'b0) else begin
            errors++;
            $error("FAIL %s/wait_timeout: observed EMPTY=%0b expected 0 within %0d cycles", phase, EMPTY, budget);
        end
    endtask

    logic [DW-1:0] vals [8] = '{8'hB9, 8'h64, 8'h3E, 8'h2A, 8'h1D, 8'h48, 8'hBF, 8'h5C};

    initial begin
        model_reset();

        phase = "reset";
        do_reset(2);
        cycle(1'b0, '0, 1'b1);
        chk("pop_on_empty", {7'b0, EMPTY}, 8'h01);

        phase = "single";
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, vals[i], 1'b0);
            wait_data(10);
            chk("single_data", RD_DATA, vals[i]);
            cycle(1'b0, '0, 1'b1);
            chk("single_empty", {7'b0, EMPTY}, 8'h01);
        end

        phase = "fill";
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, DW'(i), 1'b0);
        end
        chk("full_at_8th", {7'b0, FULL}, 8'h01);
        cycle(1'b1, 8'hFF, 1'b0);
        chk("full_hold", {7'b0, FULL}, 8'h01);

        phase = "drain";
        for (int i = 0; i < DEPTH; i++) begin
            chk("pop_order", RD_DATA, DW'(i));
            cycle(1'b0, '0, 1'b1);
        end
        chk("empty_at_8th", {7'b0, EMPTY}, 8'h01);
        cycle(1'b0, '0, 1'b1);
        chk("ninth_pop", {7'b0, EMPTY}, 8'h01);

        phase = "stream";
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, DW'($urandom), 1'b0);
        end
        wait_data(10);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, DW'($urandom), 1'b1);
        end

        phase = "random";
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));
        end

        phase = "flush";
        for (int i = 0; i < 40 && (mq.size() != 0 || !m_empty); i++) begin
            cycle(1'b0, '0, 1'b1);
        end
        chk("flush_count", DW'(mq.size()), 8'h00);
        chk("flush_empty", {7'b0, EMPTY}, 8'h01);

        phase = "midreset";
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, DW'(8'h10 + i), 1'b0);
        end
        do_reset(1);
        cycle(1'b1, 8'hA5, 1'b0);
        wait_data(10);
        chk("after_reset_data", RD_DATA, 8'hA5);
        cycle(1'b0, '0, 1'b1);
        chk("after_reset_empty", {7'b0, EMPTY}, 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
